fir_tap_line: RTL and testbench
===============================

// Module: fir_tap_line
// PURPOSE
//  Input stage of the 10-tap ROM-lookup FIR. Takes one 4-bit sample per
//  qualified cycle and maintains the tap delay line that drives x_0..x_9 of
//  the FIR core. Tracks fill level and emits result_valid, aligned to the
//  cycle on which the FIR core's 11-bit sum reflects a full window.
// PARAMETERS
//  TAPS     10  number of delay-line taps; must match the FIR core
//  W        4   sample width (bits); also the ROM address width
//  ROM_LAT  1   clocked ROM read latency inside the FIR core (0..3)
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  sample_in     in   W       new input sample
//  sample_valid  in   1       sample_in is qualified this cycle
//  clear         in   1       synchronous flush of the delay line
//  taps          out  TAPS*W  flat tap bus: [W-1:0]=x_0 (newest) ... top slice=x_9 (oldest)
//  fill_level    out  4       samples held, saturates at TAPS
//  taps_full     out  1       fill_level == TAPS
//  result_valid  out  1       FIR core output is valid for a full window this cycle
// BEHAVIOUR
//  - Reset (async, rst=1): taps=0, fill_level=0, taps_full=0, result_valid=0,
//    all internal valid-pipe stages=0. Outputs hold these values while rst=1.
//  - Shift: on posedge clk with sample_valid=1 and clear=0: x_0<=sample_in,
//    x_k<=x_(k-1) for k=1..TAPS-1, old x_(TAPS-1) discarded.
//    Updated taps are visible 1 cycle after the qualifying edge.
//  - No shift when sample_valid=0: taps, fill_level and taps_full hold.
//  - fill_level: +1 per shift, saturates at TAPS, never wraps.
//    taps_full is registered and asserts in the same cycle fill_level reaches TAPS.
//  - clear=1: takes priority over sample_valid. Next cycle: taps=0,
//    fill_level=0, taps_full=0, valid pipe flushed, so no result_valid pulse
//    from any sample in flight. sample_in in that cycle is dropped.
//  - tap_upd (internal, registered): high for one cycle when the taps change
//    due to a shift that leaves fill_level==TAPS.
//  - result_valid = tap_upd delayed by ROM_LAT cycles.
//    With ROM_LAT=0, result_valid = tap_upd.
//    It is a single-cycle pulse per qualifying shift; back-to-back shifts give
//    back-to-back pulses.
//  - No backpressure: the FIR core is fully pipelined with no stall, so every
//    valid sample is accepted.
//  - Reset mid-stream discards all in-flight valids. The first result_valid
//    after reset requires TAPS new samples.
// STRUCTURE
//  - Shared package fir_pkg: TAPS, W, ROM_LAT, OUT_W=11 and the tap-slice index
//    function. The FIR core and this block both import it.
//  - One sub-module, valid_delay: ROM_LAT-deep 1-bit shift pipe with async rst
//    and synchronous flush. It produces result_valid from tap_upd.
//  - Delay line and fill counter live in this module: one always block per
//    register group.
// TESTING
//  1. rst=1 mid-cycle -> all outputs 0 immediately; held until rst=0.
//  2. Samples 1..10 on consecutive cycles -> after 10th: x_0=10 ... x_9=1,
//     fill_level=10, taps_full=1; result_valid pulses exactly ROM_LAT+1
//     cycles after the 10th edge.
//  3. Sample 11 (=0xF) -> x_0=0xF, x_9=2; fill_level stays 10; one more pulse.
//  4. Samples 1..10 with sample_valid low on alternate cycles -> taps hold in
//     gaps; taps end as in test 2; exactly one result_valid pulse.
//  5. clear with sample_valid=1 after 5 samples -> taps=0, fill_level=0,
//     sample dropped; 10 further samples are needed before the next pulse.
//  6. clear asserted 1 cycle after the 10th sample, ROM_LAT=1 -> the in-flight
//     result_valid is suppressed; no pulse.

Source files
------------

// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared constants for the 10-tap ROM-lookup FIR and its input stage.
//   FIR_TAPS    : number of delay-line taps
//   FIR_W       : sample width, also the ROM address width
//   FIR_ROM_LAT : clocked ROM read latency inside the FIR core (0..3)
//   FIR_OUT_W   : width of the FIR core sum
//   tap_lsb()   : LSB position of tap k inside the flat tap bus
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_TAPS    = 10;
  localparam int FIR_W       = 4;
  localparam int FIR_ROM_LAT = 1;
  localparam int FIR_OUT_W   = 11;

  // Tap k occupies bits [k*w +: w] of the flat bus; x_0 is the newest sample.
  function automatic int tap_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fir_tap_line_valid_delay.sv
// ---------------------------------------------------------------------------
// valid_delay
// DEPTH-deep 1-bit shift pipe that carries the tap-update strobe through the
// ROM read latency of the FIR core. DEPTH=0 passes the input straight through.
//   clk   : system clock, rising edge
//   rst   : asynchronous reset, active-high
//   flush : synchronous clear of every stage
//   d     : strobe in
//   q     : strobe delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0] pipe_r;

      // Strobe pipe: cleared by reset or flush, otherwise shifts one stage per cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_r <= '0;
        end else if (flush) begin
          pipe_r <= '0;
        end else begin
          pipe_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign q = pipe_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fir_tap_line.sv
// ---------------------------------------------------------------------------
// fir_tap_line
// Input stage of the 10-tap ROM-lookup FIR. Shifts one sample per qualified
// cycle into the tap delay line, tracks how many samples are held, and flags
// the cycle on which the FIR core sum reflects a full window.
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active-high
//   sample_in    : new input sample
//   sample_valid : sample_in is qualified this cycle
//   clear        : synchronous flush of the delay line (wins over sample_valid)
//   taps         : flat tap bus, [W-1:0] = x_0 (newest) ... top slice = x_9
//   fill_level   : samples held, saturates at TAPS
//   taps_full    : fill_level == TAPS
//   result_valid : FIR core output covers a full window this cycle
// ---------------------------------------------------------------------------
module fir_tap_line
  import fir_pkg::*;
#(
  parameter int TAPS    = FIR_TAPS,
  parameter int W       = FIR_W,
  parameter int ROM_LAT = FIR_ROM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      sample_in,
  input  logic              sample_valid,
  input  logic              clear,
  output logic [TAPS*W-1:0] taps,
  output logic [3:0]        fill_level,
  output logic              taps_full,
  output logic              result_valid
);

  localparam logic [3:0] FILL_MAX = 4'(TAPS);

  logic [TAPS*W-1:0] taps_r;
  logic [3:0]        fill_r;
  logic              full_r;
  logic              tap_upd_r;
  logic              shift_s;
  logic [3:0]        fill_next_s;
  logic              result_valid_s;

  // Shift qualification and saturating next fill level.
  always_comb begin
    shift_s     = sample_valid & ~clear;
    fill_next_s = fill_r;
    if (fill_r == FILL_MAX) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + 4'd1;
    end
  end

  // Delay line: x_0 takes the new sample, every older tap moves up one slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_r <= '0;
    end else if (clear) begin
      taps_r <= '0;
    end else if (shift_s) begin
      taps_r[W-1:0] <= sample_in;
      for (int k = 1; k < TAPS; k++) begin
        taps_r[tap_lsb(k, W) +: W] <= taps_r[tap_lsb(k - 1, W) +: W];
      end
    end
  end

  // Fill counter and its full flag, updated together so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_r <= 4'd0;
      full_r <= 1'b0;
    end else if (clear) begin
      fill_r <= 4'd0;
      full_r <= 1'b0;
    end else if (shift_s) begin
      fill_r <= fill_next_s;
      full_r <= (fill_next_s == FILL_MAX);
    end
  end

  // One-cycle strobe for every shift that leaves the window full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_upd_r <= 1'b0;
    end else if (clear) begin
      tap_upd_r <= 1'b0;
    end else begin
      tap_upd_r <= shift_s & (fill_next_s == FILL_MAX);
    end
  end

  // Align the strobe with the ROM read latency of the FIR core; clear kills
  // any strobe still in flight.
  valid_delay #(
    .DEPTH (ROM_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (clear),
    .d     (tap_upd_r),
    .q     (result_valid_s)
  );

  assign taps         = taps_r;
  assign fill_level   = fill_r;
  assign taps_full    = full_r;
  assign result_valid = result_valid_s;

endmodule

// File: tb/tb_fir_tap_line.sv
module tb_fir_tap_line;
  import fir_pkg::*;

  localparam int TAPS    = FIR_TAPS;
  localparam int W       = FIR_W;
  localparam int ROM_LAT = FIR_ROM_LAT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [W-1:0]      sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              clear = 1'b0;
  logic [TAPS*W-1:0] taps;
  logic [3:0]        fill_level;
  logic              taps_full;
  logic              result_valid;

  fir_tap_line #(.TAPS(TAPS), .W(W), .ROM_LAT(ROM_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear        (clear),
    .taps         (taps),
    .fill_level   (fill_level),
    .taps_full    (taps_full),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int pulse_cnt = 0;

  // Reference model: sample history (newest first), fill count and a
  // scoreboard of edge numbers after which a result_valid pulse is due.
  logic [W-1:0] hist[$];
  int           fill_m = 0;
  int           sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TAPS*W-1:0] exp_taps();
    logic [TAPS*W-1:0] v;
    v = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (k < hist.size()) v[k*W +: W] = hist[k];
    end
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    fill_m = 0;
    sb.delete();
  endtask

  // Drive one cycle, let the DUT take it, then advance the model.
  task automatic step(input logic v, input logic [W-1:0] s, input logic c);
    sample_valid = v;
    sample_in    = s;
    clear        = c;
    @(posedge clk);
    edge_cnt++;
    if (c) begin
      hist.delete();
      fill_m = 0;
      while (sb.size() > 0 && sb[$] >= edge_cnt) void'(sb.pop_back());
    end else if (v) begin
      hist.push_front(s);
      if (hist.size() > TAPS) void'(hist.pop_back());
      if (fill_m < TAPS) fill_m++;
      if (fill_m == TAPS) sb.push_back(edge_cnt + ROM_LAT);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_taps"}, 64'(taps), 64'd0);
    chk({tag, "_fill"}, 64'(fill_level), 64'd0);
    chk({tag, "_full"}, 64'(taps_full), 64'd0);
    chk({tag, "_rv"}, 64'(result_valid), 64'd0);
  endtask

  // Monitor: state compared every cycle, pulses popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      chk("mon_taps", 64'(taps), 64'(exp_taps()));
      chk("mon_fill", 64'(fill_level), 64'(fill_m));
      chk("mon_full", 64'(taps_full), 64'(fill_m == TAPS));
      if (result_valid) begin
        pulse_cnt++;
        if (sb.size() == 0) begin
          chk("rv_unexpected", 64'd1, 64'd0);
        end else begin
          chk("rv_time", 64'(edge_cnt), 64'(sb[0]));
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && sb[0] <= edge_cnt) begin
        chk("rv_missing", 64'd0, 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int p0;
    // Test 1: reset from time zero holds outputs at zero.
    #3 chk_zero("t1_rst_a");
    #9 chk_zero("t1_rst_b");
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 2: samples 1..10 back to back.
    p0 = pulse_cnt;
    for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b0);
    chk("t2_x0", 64'(taps[W-1:0]), 64'd10);
    chk("t2_x9", 64'(taps[TAPS*W-1 -: W]), 64'd1);
    chk("t2_fill", 64'(fill_level), 64'd10);
    chk("t2_full", 64'(taps_full), 64'd1);
    idle(ROM_LAT + 2);
    chk("t2_pulses", 64'(pulse_cnt - p0), 64'd1);

    // Test 3: one more sample at saturation.
    p0 = pulse_cnt;
    step(1'b1, 4'hF, 1'b0);
    chk("t3_x0", 64'(taps[W-1:0]), 64'hF);
    chk("t3_x9", 64'(taps[TAPS*W-1 -: W]), 64'd2);
    chk("t3_fill", 64'(fill_level), 64'd10);
    idle(ROM_LAT + 2);
    chk("t3_pulses", 64'(pulse_cnt - p0), 64'd1);

    // Test 4: samples on alternate cycles after a clear.
    step(1'b0, '0, 1'b1);
    p0 = pulse_cnt;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, W'(i), 1'b0);
      step(1'b0, 4'h7, 1'b0);
    end
    chk("t4_x0", 64'(taps[W-1:0]), 64'd10);
    chk("t4_x9", 64'(taps[TAPS*W-1 -: W]), 64'd1);
    idle(ROM_LAT + 2);
    chk("t4_pulses", 64'(pulse_cnt - p0), 64'd1);

    // Test 5: clear together with a valid sample drops that sample.
    step(1'b0, '0, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, 4'h9, 1'b1);
    chk("t5_taps", 64'(taps), 64'd0);
    chk("t5_fill", 64'(fill_level), 64'd0);
    p0 = pulse_cnt;
    for (int i = 1; i <= 9; i++) step(1'b1, W'(i + 3), 1'b0);
    idle(ROM_LAT + 2);
    chk("t5_no_pulse", 64'(pulse_cnt - p0), 64'd0);
    step(1'b1, 4'h2, 1'b0);
    idle(ROM_LAT + 2);
    chk("t5_pulse", 64'(pulse_cnt - p0), 64'd1);

    // Test 6: clear right after the 10th sample kills the in-flight pulse.
    step(1'b0, '0, 1'b1);
    p0 = pulse_cnt;
    for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    idle(ROM_LAT + 2);
    chk("t6_pulses", 64'(pulse_cnt - p0), (ROM_LAT == 0) ? 64'd1 : 64'd0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 32) == 0);
    end
    idle(ROM_LAT + 2);

    // Mid-stream reset with a pulse in flight.
    for (int i = 1; i <= 10; i++) step(1'b1, W'($urandom), 1'b0);
    #1;
    rst = 1'b1;
    model_reset();
    #1 chk_zero("t1_mid_a");
    repeat (2) @(posedge clk);
    #1 chk_zero("t1_mid_b");
    rst = 1'b0;
    p0 = pulse_cnt;
    for (int i = 1; i <= 9; i++) step(1'b1, W'($urandom), 1'b0);
    idle(ROM_LAT + 2);
    chk("rst_no_pulse", 64'(pulse_cnt - p0), 64'd0);
    step(1'b1, W'($urandom), 1'b0);
    idle(ROM_LAT + 2);
    chk("rst_pulse", 64'(pulse_cnt - p0), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
